mem_access_ctrl: RTL

Sequences data-memory accesses for the MEM stage of the 5-stage RV32I pipeline. It takes the load/store request and the already-forwarded store data, and builds word-aligned bus transactions with byte enables. It drives a req/gnt/rvalid data-memory bus, stalls the pipeline while the access is outstanding, and returns a sign- or zero-extended load result to the MEM/WB register. Misaligned accesses are flagged and never reach the bus.

---
 rtl/pipe_pkg.sv | 38 +++
 rtl/mem_lane_align.sv | 62 ++++++
 rtl/mem_access_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared MEM-stage definitions: funct3 access encodings, memory FSM states,
// byte-enable patterns and the alignment rule used by the load/store unit.
package pipe_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    DONE   = 2'd3
  } mem_state_t;

  // Size comes from funct3[1:0]; the unsigned bit (funct3[2]) never affects alignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (size)
      SZ_H:    mis = addr_lo[0];
      SZ_W:    mis = |addr_lo;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Pure combinational lane steering: store byte-enables/replicated data, and
// load byte/half extraction with sign or zero extension. Zero latency.
module mem_lane_align
  import pipe_pkg::*;
(
  input  logic [1:0]  i_st_size,
  input  logic [1:0]  i_st_addr_lo,
  input  logic [31:0] i_st_wdata,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_addr_lo,
  input  logic [31:0] i_ld_rdata,
  output logic [3:0]  o_st_be,
  output logic [31:0] o_st_wdata,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_st_be    = BE_W;
    o_st_wdata = i_st_wdata;
    case (i_st_size)
      SZ_B: begin
        o_st_be    = BE_B << i_st_addr_lo;
        o_st_wdata = {4{i_st_wdata[7:0]}};
      end
      SZ_H: begin
        o_st_be    = BE_H << {i_st_addr_lo[1], 1'b0};
        o_st_wdata = {2{i_st_wdata[15:0]}};
      end
      default: begin
        o_st_be    = BE_W;
        o_st_wdata = i_st_wdata;
      end
    endcase
  end

  always_comb begin
    w_byte = i_ld_rdata[7:0];
    case (i_ld_addr_lo)
      2'd0: w_byte = i_ld_rdata[7:0];
      2'd1: w_byte = i_ld_rdata[15:8];
      2'd2: w_byte = i_ld_rdata[23:16];
      2'd3: w_byte = i_ld_rdata[31:24];
      default: w_byte = i_ld_rdata[7:0];
    endcase
    w_half = i_ld_addr_lo[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];
  end

  always_comb begin
    o_ld_data = i_ld_rdata;
    case (i_ld_funct3)
      F3_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_ld_data = {24'd0, w_byte};
      F3_H:    o_ld_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_ld_data = {16'd0, w_half};
      default: o_ld_data = i_ld_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer on a req/gnt/rvalid bus; stalls the pipe until done.
// Immediate grant: store stalls 2 cycles, load 3 (+rvalid delay); waits indefinitely on gnt/rvalid.
module mem_access_ctrl
  import pipe_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] load_data_o,
  output logic              load_valid_o,
  output logic              misalign_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_be_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rvalid_i,
  input  logic [DATA_W-1:0] bus_rdata_i
);

  mem_state_t        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_be;
  logic [DATA_W-1:0] r_wdata;
  logic [2:0]        r_funct3;
  logic              r_we;
  logic              r_drop;
  logic [DATA_W-1:0] r_load_data;
  logic              r_load_valid;
  logic              r_misalign;

  logic              w_access;
  logic              w_mis;
  logic              w_start;
  logic              w_stall;
  logic [3:0]        w_st_be;
  logic [DATA_W-1:0] w_st_wdata;
  logic [DATA_W-1:0] w_ld_data;

  assign w_access = (mem_read_i | mem_write_i) & ~flush_i;
  assign w_mis    = is_misaligned(funct3_i[1:0], addr_i[1:0]);
  assign w_start  = (r_state == IDLE) & w_access & ~w_mis;

  mem_lane_align u_lane (
    .i_st_size    (funct3_i[1:0]),
    .i_st_addr_lo (addr_i[1:0]),
    .i_st_wdata   (wdata_i),
    .i_ld_funct3  (r_funct3),
    .i_ld_addr_lo (r_addr[1:0]),
    .i_ld_rdata   (bus_rdata_i),
    .o_st_be      (w_st_be),
    .o_st_wdata   (w_st_wdata),
    .o_ld_data    (w_ld_data)
  );

  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      IDLE:    w_stall = w_start;
      REQ:     w_stall = ~flush_i;
      WAIT_R:  w_stall = 1'b1;
      DONE:    w_stall = 1'b0;
      default: w_stall = 1'b0;
    endcase
  end

  // A flush in REQ withdraws the request in the same cycle, so any grant seen then is void.
  assign bus_req_o    = (r_state == REQ) & ~flush_i & ~rst;
  assign stall_o      = w_stall & ~rst;
  assign bus_we_o     = r_we;
  assign bus_addr_o   = {r_addr[ADDR_W-1:2], 2'b00};
  assign bus_be_o     = r_be;
  assign bus_wdata_o  = r_wdata;
  assign load_data_o  = r_load_data;
  assign load_valid_o = r_load_valid;
  assign misalign_o   = r_misalign;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_be         <= '0;
      r_wdata      <= '0;
      r_funct3     <= '0;
      r_we         <= 1'b0;
      r_drop       <= 1'b0;
      r_load_data  <= '0;
      r_load_valid <= 1'b0;
      r_misalign   <= 1'b0;
    end else begin
      r_load_valid <= 1'b0;
      r_misalign   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_access && w_mis) begin
            r_misalign <= 1'b1;
          end else if (w_start) begin
            r_addr   <= addr_i;
            r_be     <= w_st_be;
            r_wdata  <= w_st_wdata;
            r_funct3 <= funct3_i;
            r_we     <= mem_write_i;
            r_drop   <= 1'b0;
            r_state  <= REQ;
          end
        end
        REQ: begin
          if (flush_i) begin
            r_state <= IDLE;
          end else if (bus_gnt_i) begin
            r_state <= r_we ? DONE : WAIT_R;
          end
        end
        WAIT_R: begin
          if (flush_i) begin
            r_drop <= 1'b1;
          end
          // The bus read cannot be abandoned; a killed load still drains its rvalid.
          if (bus_rvalid_i) begin
            if (r_drop || flush_i) begin
              r_state <= IDLE;
            end else begin
              r_load_data  <= w_ld_data;
              r_load_valid <= 1'b1;
              r_state      <= DONE;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
